// File: rtl/msg_rx_pkg.sv
// Shared types, constants and helpers for the serial message receiver.
// MSG_RX_PARITY_EN (optional) adds an even-parity bit to the frame.
package msg_rx_pkg;

    localparam int MSG_W_DEF      = 5;
    localparam int BIT_CYCLES_DEF = 16;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_LVL = 1'b0;
    localparam logic STOP_LVL  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    // True when the data bits together with their parity bit hold an even number of ones.
    function automatic logic even_parity_ok(input logic [31:0] bits);
        return ((^bits) == 1'b0);
    endfunction

endpackage

// File: rtl/msg_bit_timer.sv
// Bit-period down-counter: load half or full period, tick marks the terminal count (0).
// Holds at 0 when not reloaded, so it rests at 0 while the receiver is idle.
module msg_bit_timer
    import msg_rx_pkg::*;
#(
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic load_half,
    input  logic load_full,
    output logic tick
);

    localparam int CNT_W = $clog2(BIT_CYCLES);

    logic [CNT_W-1:0] cnt_r;

    // Countdown register; a full reload wins over a half reload.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load_full) begin
            cnt_r <= CNT_W'(BIT_CYCLES - 1);
        end else if (load_half) begin
            cnt_r <= CNT_W'(BIT_CYCLES / 2 - 1);
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/message_receiver.sv
// Serial-to-parallel frame receiver: start detect, mid-bit sampling, stop/parity check.
// Optional build macro: MSG_RX_PARITY_EN (even parity bit between data and stop).
module message_receiver
    import msg_rx_pkg::*;
#(
    parameter int MSG_W      = MSG_W_DEF,
    parameter int BIT_CYCLES = BIT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             data,
    output logic [MSG_W-1:0] message,
    output logic             valid,
    output logic             frame_err,
    output logic             busy
);

    localparam int IDX_W = (MSG_W > 1) ? $clog2(MSG_W) : 1;

    rx_state_e        state_r, state_nx_s;
    logic             sync1_r, ds_r;
    logic [MSG_W-1:0] shift_r;
    logic [IDX_W-1:0] bit_idx_r;
    logic [MSG_W-1:0] message_r;
    logic             valid_r, frame_err_r, busy_r;
    logic             tick_s, load_half_s, load_full_s;
    logic             shift_en_s, idx_init_s, idx_dec_s, par_cap_s;
    logic             valid_s, frame_err_s, par_ok_s;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_r <= LINE_IDLE;
            ds_r    <= LINE_IDLE;
        end else begin
            sync1_r <= data;
            ds_r    <= sync1_r;
        end
    end

    msg_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load_half (load_half_s),
        .load_full (load_full_s),
        .tick      (tick_s)
    );

`ifdef MSG_RX_PARITY_EN
    logic parity_r;

    // Parity bit capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            parity_r <= 1'b0;
        end else if (par_cap_s) begin
            parity_r <= ds_r;
        end else begin
            parity_r <= parity_r;
        end
    end

    assign par_ok_s = even_parity_ok(32'({shift_r, parity_r}));
`else
    assign par_ok_s = 1'b1;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state and datapath strobes; every decision is taken at a timer tick.
    always_comb begin
        state_nx_s  = state_r;
        load_half_s = 1'b0;
        load_full_s = 1'b0;
        shift_en_s  = 1'b0;
        idx_init_s  = 1'b0;
        idx_dec_s   = 1'b0;
        par_cap_s   = 1'b0;
        valid_s     = 1'b0;
        frame_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ds_r == START_LVL) begin
                    state_nx_s  = ST_START;
                    load_half_s = 1'b1;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (ds_r == START_LVL) begin
                        state_nx_s  = ST_DATA;
                        load_full_s = 1'b1;
                        idx_init_s  = 1'b1;
                    end else begin
                        state_nx_s  = ST_IDLE;
                    end
                end else begin
                    state_nx_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shift_en_s  = 1'b1;
                    load_full_s = 1'b1;
                    if (bit_idx_r == {IDX_W{1'b0}}) begin
`ifdef MSG_RX_PARITY_EN
                        state_nx_s = ST_PARITY;
`else
                        state_nx_s = ST_STOP;
`endif
                    end else begin
                        idx_dec_s  = 1'b1;
                    end
                end else begin
                    state_nx_s = ST_DATA;
                end
            end
`ifdef MSG_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    par_cap_s   = 1'b1;
                    load_full_s = 1'b1;
                    state_nx_s  = ST_STOP;
                end else begin
                    state_nx_s  = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    if ((ds_r == STOP_LVL) && par_ok_s) begin
                        valid_s     = 1'b1;
                        state_nx_s  = ST_IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_nx_s  = ST_WAIT_HIGH;
                    end
                end else begin
                    state_nx_s = ST_STOP;
                end
            end
            ST_WAIT_HIGH: begin
                // A line stuck low must not be mistaken for a stream of start bits.
                if (ds_r == LINE_IDLE) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT_HIGH;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Shift register (MSB arrives first) and bit index.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_r   <= {MSG_W{1'b0}};
            bit_idx_r <= {IDX_W{1'b0}};
        end else begin
            if (shift_en_s) begin
                shift_r <= {shift_r[MSG_W-2:0], ds_r};
            end
            if (idx_init_s) begin
                bit_idx_r <= IDX_W'(MSG_W - 1);
            end else if (idx_dec_s) begin
                bit_idx_r <= bit_idx_r - IDX_W'(1);
            end
        end
    end

    // Registered outputs; busy follows the state being entered so it aligns with state_r.
    always_ff @(posedge clk) begin
        if (!rst) begin
            message_r   <= {MSG_W{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            valid_r     <= valid_s;
            frame_err_r <= frame_err_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            if (valid_s) begin
                message_r <= shift_r;
            end
        end
    end

    assign message   = message_r;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
    assign busy      = busy_r;

endmodule

// File: doc/message_receiver.md
# message_receiver

Serial-to-parallel receive stage that sits directly downstream of the message transmitter and consumes its one-wire `data` stream. It detects a frame start, samples each bit at mid-bit, and checks the stop bit. On a good frame it presents the recovered 5-bit message with a one-cycle `valid` strobe. Framing errors are flagged, and the receiver resynchronises without any software involvement.

## Interface
Parameters:
- `MSG_W`, 5: message width in bits.
- `BIT_CYCLES`, 16: clocks per serial bit. Must be an even number ≥ 4.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: synchronous, active-low reset; `rst==0` at a rising edge resets the block.
- `data` input 1: serial line from the transmitter; idles high; asynchronous to bit boundaries.
- `message` output MSG_W: last correctly received message; holds its value between frames.
- `valid` output 1: one-cycle pulse when `message` has just been updated.
- `frame_err` output 1: one-cycle pulse on a bad stop bit or bad parity.
- `busy` output 1: high in every state except IDLE.

## Operation
- Frame format, in order:
  - start bit `0`;
  - `MSG_W` data bits, MSB first;
  - optional parity bit (see Configuration);
  - stop bit `1`.
  - Each bit lasts `BIT_CYCLES` clocks.
- `data` passes through a 2-flop synchroniser. All decisions use the synchronised bit `ds`.
- Bit timer counts 0..`BIT_CYCLES-1`; its terminal count is called `tick`.
- FSM states and transitions:
  - IDLE: timer held at 0. On `ds==0`, go to START.
  - START: wait `BIT_CYCLES/2` clocks, then resample.
    - If `ds==0`, go to DATA with the bit index set to `MSG_W-1`.
    - If `ds==1`, treat it as a glitch and return to IDLE. No flags.
  - DATA: on each `tick`, shift `ds` into the shift register. After the bit with index 0, go to PARITY if enabled, otherwise STOP.
  - PARITY: on `tick`, capture the parity bit, then go to STOP.
  - STOP: on `tick`, sample `ds`.
    - If `ds==1` and parity is OK: load `message` from the shift register, pulse `valid`, go to IDLE.
    - Otherwise: pulse `frame_err`, leave `message` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `ds==1`, then go to IDLE. This prevents a held-low line from being read as back-to-back frames.
- `valid` and `frame_err` are never high in the same cycle.
- The line level during a frame is not rechecked mid-bit. Only the sample points matter.

## Timing
- Reset values:
  - `message` = 0, `valid` = 0, `frame_err` = 0, `busy` = 0.
  - Synchroniser flops = 1.
  - FSM in IDLE, timer 0.
- Start detection: `ds` falls 2 clocks after `data` falls. The FSM reaches START on the following edge.
- Sample points sit at `BIT_CYCLES/2 + k·BIT_CYCLES` clocks after START entry, for k = 1..(number of bits after start).
- `valid` / `frame_err` assert on the clock after the stop-bit sample point. `message` updates in the same cycle that `valid` is high.
- Frame-to-frame: a new start bit may begin on the clock immediately after the stop-bit sample. It is accepted because STOP returns to IDLE in one cycle.
- Reset mid-frame: on the next edge the FSM is in IDLE, partial data is discarded, and no `valid` or `frame_err` pulse is produced.
- `message` is unchanged by reset-free error paths.

## Configuration
- `MSG_RX_PARITY_EN` defined:
  - Frame carries an even-parity bit after the data bits; the PARITY state exists.
  - Parity mismatch with a good stop bit → `frame_err` pulse, no `valid`.
- `MSG_RX_PARITY_EN` undefined:
  - No parity bit; the PARITY state and its logic are not compiled.
  - The frame is `MSG_W+2` bits long.

## Structure
- Package `msg_rx_pkg`:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - `MSG_W_DEF = 5`, `BIT_CYCLES_DEF = 16`;
  - `LINE_IDLE = 1'b1`, `START_LVL = 1'b0`, `STOP_LVL = 1'b1`.
- Sub-module `msg_bit_timer`: parameterised down-counter with `load_half`, `load_full` and `tick` output. It is instantiated once.
- The synchroniser and FSM live in the top.

## Test plan
- Reset: hold `rst=0` 3 clocks with `data` toggling → `message=0`, `valid=0`, `frame_err=0`, `busy=0`.
- Single frame: `BIT_CYCLES=4`, send `10101` with a good stop bit → one `valid` pulse, `message=5'b10101`, no `frame_err`.
- Back-to-back: frames `00001` then `11110` with no idle gap → two `valid` pulses 28 clocks apart (7 bits × 4, parity off), with `message` equal to each frame in turn.
- Bad stop: send `01100` with stop bit `0`, line held low for 20 clocks, then high → one `frame_err`, `message` unchanged, `busy` stays high until 3 clocks after the line rises, and no spurious frame.
- Glitch: a 1-clock low pulse on idle `data` → FSM returns to IDLE, no `valid`, no `frame_err`.
- With `MSG_RX_PARITY_EN`: send `10101` with parity bit `0` → `frame_err`; send again with parity bit `1` → `valid`, `message=5'b10101`.
- Mid-frame reset (additional): assert `rst=0` during data bit 2 → no pulses, `busy=0` on the next clock, and the next clean frame is received correctly.
